gate_selftest: RTL and testbench
================================

# gate_selftest

Self-test sequencer and checker for the two-input logic-gate stage. It drives the gate stage's `a`/`b` inputs through the full truth table and samples the seven gate outputs after a programmable settle time. Each output is compared against a golden model, and the block reports a sticky per-gate fail mask, a saturating error count and a pass flag. It sits on both sides of the gate stage: its drive outputs feed it and its check inputs consume it.

## Interface
- `SETTLE_CYCLES`, default 2: extra cycles each vector is held before sampling; legal 0..15.
- `NUM_PASSES`, default 1: number of full truth-table sweeps per run; legal 1..255.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  run request; sampled only in IDLE.
- `a_drv`  out  1  drive to gate input A.
- `b_drv`  out  1  drive to gate input B.
- `gate_in`  in  7  gate outputs; [0]=and, [1]=or, [2]=not(A), [3]=nand, [4]=nor, [5]=xor, [6]=xnor.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  high when the last completed run had no mismatch.
- `fail_mask`  out  7  sticky per-gate mismatch flags, same bit order as `gate_in`.
- `err_count`  out  8  total mismatching bits; saturates at 255.

## Operation
- **FSM states:**
  - IDLE to RUN on `start`.
  - RUN holds the current vector for SETTLE_CYCLES+1 cycles. It samples on the last cycle of each vector, then advances the vector.
  - After the final sample of the final pass, RUN goes to DONE.
  - DONE lasts one cycle, then returns to IDLE.
- **Vector order:** `vec[1:0]` = {A,B} = 00, 01, 10, 11, repeated NUM_PASSES times. `a_drv` = vec[1] and `b_drv` = vec[0], both registered.
- **Golden model:** expected = {~(a^b), a^b, ~(a|b), ~(a&b), ~a, a|b, a&b} for the current vector.
- **Per sample:**
  - mismatch = expected ^ gate_in.
  - fail_mask |= mismatch.
  - err_count += popcount(mismatch), clamped at 255.
- **Start acceptance:** on accepting `start`, `fail_mask`, `err_count` and `pass` clear to 0 in the same cycle the first vector appears.
- `pass` = (fail_mask == 0), updated only in DONE. Results hold in IDLE until the next accepted `start`.
- `start` is ignored in RUN and DONE; no queuing.
- **Outside RUN:** `a_drv`/`b_drv` are 0 in IDLE and DONE.

## Timing
- **Reset values:** all outputs are 0 and the state is IDLE. `rst` asserted mid-run aborts immediately: the next cycle is IDLE with all outputs 0 and no `done` pulse.
- **Start latency:** `start` high in IDLE at cycle T gives `busy`=1 and vector 00 on `a_drv`/`b_drv` from T+1.
- **Vector timing:** each vector occupies SETTLE_CYCLES+1 cycles. `gate_in` is sampled on the last of these, so the gate stage sees SETTLE_CYCLES+1 cycles of settle including combinational delay.
- **Run length:** L = 4·(SETTLE_CYCLES+1)·NUM_PASSES cycles. `busy` is high from T+1 to T+L.
- **End of run:**
  - `done`=1 and `pass` is valid at T+L+1.
  - `busy`=0 at T+L+1.
  - A new `start` is accepted from T+L+2.
- **Counter clamp:** if an increment would exceed 255, the count holds at 255. There is no wrap.
- **Final sample:** the last sample's update to `fail_mask`/`err_count` is visible in the same cycle `done` is high.

## Structure
- **Package `gate_selftest_pkg`:**
  - gate index constants GATE_AND..GATE_XNOR (0..6);
  - the state enum {IDLE, RUN, DONE};
  - function `gate_expected(a,b)` returning the 7-bit golden vector.
- **Sub-module `gate_golden`:** combinational wrapper around `gate_expected` plus a 7-bit popcount. Kept separate so the golden model is reusable by benches.
- **Top level:** FSM, settle counter (4 bits), vector counter (2 bits), pass counter (8 bits) and result registers.

## Test plan
- **Correct gate stage:** ideal gate stage, defaults, `start` at T → `busy` T+1..T+12; `done` at T+13; pass=1, fail_mask=0, err_count=0.
- **xor stuck-at-0:** `gate_in[5]` forced 0, defaults → fail_mask=7'b0100000 and err_count=2 (vectors 01, 10); pass=0.
- **Inverted NOT:** `gate_in[2]` inverted, NUM_PASSES=3 → fail_mask=7'b0000100 and err_count=12.
- **Saturation:** all seven bits inverted, SETTLE_CYCLES=0, NUM_PASSES=10 → err_count=255 (not 280 mod 256); fail_mask=7'h7F; `done` at T+41.
- **Start during run:** `start` re-pulsed during RUN at T+5 → ignored; `done` still at T+13; results unchanged.
- **Reset mid-run:** `rst` at T+6 → IDLE next cycle; all outputs 0; no `done`; a fresh `start` then completes normally.

Source files
------------

// File: rtl/gate_selftest_pkg.sv
// Shared definitions for the gate-stage self-test: widths, gate bit indices,
// sequencer states and the golden truth function.
package gate_selftest_pkg;

   localparam int unsigned GATE_W   = 7;
   localparam int unsigned ERR_W    = 8;
   localparam int unsigned SUM_W    = ERR_W + 1;
   localparam int unsigned SETTLE_W = 4;
   localparam int unsigned VEC_W    = 2;
   localparam int unsigned PASS_W   = 8;
   localparam int unsigned CNT_W    = 3;

   localparam int unsigned GATE_AND  = 0;
   localparam int unsigned GATE_OR   = 1;
   localparam int unsigned GATE_NOT  = 2;
   localparam int unsigned GATE_NAND = 3;
   localparam int unsigned GATE_NOR  = 4;
   localparam int unsigned GATE_XOR  = 5;
   localparam int unsigned GATE_XNOR = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Golden output of an ideal gate stage for inputs a, b.
   function automatic logic [GATE_W-1:0] gate_expected(input logic a, input logic b);
      logic [GATE_W-1:0] e;
      e            = '0;
      e[GATE_AND]  = a & b;
      e[GATE_OR]   = a | b;
      e[GATE_NOT]  = ~a;
      e[GATE_NAND] = ~(a & b);
      e[GATE_NOR]  = ~(a | b);
      e[GATE_XOR]  = a ^ b;
      e[GATE_XNOR] = ~(a ^ b);
      return e;
   endfunction

endpackage

// File: rtl/gate_selftest_golden.sv
// Combinational golden model: expected gate outputs, mismatch vector and
// number of mismatching bits for one {A,B} vector.
module gate_golden
   import gate_selftest_pkg::*;
(
   input  logic              a_i,
   input  logic              b_i,
   input  logic [GATE_W-1:0] gate_i,
   output logic [GATE_W-1:0] expected_c_o,
   output logic [GATE_W-1:0] mismatch_c_o,
   output logic [CNT_W-1:0]  mis_cnt_c_o
);

   always_comb begin
      expected_c_o = gate_expected(a_i, b_i);
      mismatch_c_o = expected_c_o ^ gate_i;
      mis_cnt_c_o  = '0;
      for (int i = 0; i < int'(GATE_W); i++) begin
         mis_cnt_c_o = mis_cnt_c_o + CNT_W'(mismatch_c_o[i]);
      end
   end

endmodule

// File: rtl/gate_selftest.sv
// Self-test sequencer: sweeps {A,B} through the truth table NUM_PASSES times,
// checks the gate stage against the golden model and accumulates results.
module gate_selftest
   import gate_selftest_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned NUM_PASSES    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              a_drv,
   output logic              b_drv,
   input  logic [GATE_W-1:0] gate_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [GATE_W-1:0] fail_mask,
   output logic [ERR_W-1:0]  err_count
);

   state_t              state_q, state_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [VEC_W-1:0]    vec_q, vec_d;
   logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
   logic                a_q, a_d, b_q, b_d;
   logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [GATE_W-1:0]   mask_q, mask_d;
   logic [ERR_W-1:0]    err_q, err_d;

   logic [GATE_W-1:0]   expected_c, mismatch_c;
   logic [CNT_W-1:0]    mis_cnt_c;
   logic [SUM_W-1:0]    err_sum_c;
   logic                settle_end_c, last_vec_c, last_pass_c;

   gate_golden u_golden (
      .a_i          (vec_q[1]),
      .b_i          (vec_q[0]),
      .gate_i       (gate_in),
      .expected_c_o (expected_c),
      .mismatch_c_o (mismatch_c),
      .mis_cnt_c_o  (mis_cnt_c)
   );

   assign err_sum_c    = SUM_W'(err_q) + SUM_W'(mis_cnt_c);
   assign settle_end_c = (settle_q == SETTLE_W'(SETTLE_CYCLES));
   assign last_vec_c   = (vec_q == VEC_W'(3));
   assign last_pass_c  = (pass_cnt_q == PASS_W'(NUM_PASSES - 1));

   // Next-state and result update
   always_comb begin
      state_d    = state_q;
      settle_d   = settle_q;
      vec_d      = vec_q;
      pass_cnt_d = pass_cnt_q;
      a_d        = 1'b0;
      b_d        = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      pass_d     = pass_q;
      mask_d     = mask_q;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               settle_d   = '0;
               vec_d      = '0;
               pass_cnt_d = '0;
               busy_d     = 1'b1;
               pass_d     = 1'b0;
               mask_d     = '0;
               err_d      = '0;
            end
         end
         RUN: begin
            busy_d = 1'b1;
            if (settle_end_c) begin
               mask_d   = mask_q | mismatch_c;
               err_d    = err_sum_c[SUM_W-1] ? {ERR_W{1'b1}} : err_sum_c[ERR_W-1:0];
               settle_d = '0;
               vec_d    = VEC_W'(vec_q + VEC_W'(1));
               if (last_vec_c) begin
                  pass_cnt_d = PASS_W'(pass_cnt_q + PASS_W'(1));
                  if (last_pass_c) begin
                     state_d = DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     pass_d  = (mask_d == '0);
                  end
               end
            end else begin
               settle_d = SETTLE_W'(settle_q + SETTLE_W'(1));
            end
            // Drive registers carry the vector the next cycle will hold
            if (state_d == RUN) begin
               a_d = vec_d[1];
               b_d = vec_d[0];
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         settle_q   <= '0;
         vec_q      <= '0;
         pass_cnt_q <= '0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         mask_q     <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         vec_q      <= vec_d;
         pass_cnt_q <= pass_cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         mask_q     <= mask_d;
         err_q      <= err_d;
      end
   end

   assign a_drv     = a_q;
   assign b_drv     = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = mask_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_gate_selftest.sv
// Directed bench for gate_selftest: three parameterisations share one bench
// gate-stage model with injectable stuck/inverted outputs.
module tb_gate_selftest;

   logic       clk;
   logic       rst;
   logic [2:0] start_v, busy_v, done_v, pass_v, a_v, b_v;
   logic [6:0] gin_v  [3];
   logic [6:0] mask_v [3];
   logic [7:0] err_v  [3];
   logic [6:0] keep_m, inv_m;

   int n_checks = 0;
   int n_fails  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench gate stage: ideal gates, then optional force-to-0 and inversion
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         logic [6:0] ideal;
         ideal    = '0;
         ideal[0] = a_v[i] & b_v[i];
         ideal[1] = a_v[i] | b_v[i];
         ideal[2] = ~a_v[i];
         ideal[3] = ~(a_v[i] & b_v[i]);
         ideal[4] = ~(a_v[i] | b_v[i]);
         ideal[5] = a_v[i] ^ b_v[i];
         ideal[6] = ~(a_v[i] ^ b_v[i]);
         gin_v[i] = (ideal & keep_m) ^ inv_m;
      end
   end

   gate_selftest #(.SETTLE_CYCLES(2), .NUM_PASSES(1)) u_def (
      .clk(clk), .rst(rst), .start(start_v[0]), .a_drv(a_v[0]), .b_drv(b_v[0]),
      .gate_in(gin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
      .fail_mask(mask_v[0]), .err_count(err_v[0]));

   gate_selftest #(.SETTLE_CYCLES(2), .NUM_PASSES(3)) u_p3 (
      .clk(clk), .rst(rst), .start(start_v[1]), .a_drv(a_v[1]), .b_drv(b_v[1]),
      .gate_in(gin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
      .fail_mask(mask_v[1]), .err_count(err_v[1]));

   gate_selftest #(.SETTLE_CYCLES(0), .NUM_PASSES(10)) u_sat (
      .clk(clk), .rst(rst), .start(start_v[2]), .a_drv(a_v[2]), .b_drv(b_v[2]),
      .gate_in(gin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
      .fail_mask(mask_v[2]), .err_count(err_v[2]));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_zero(input int inst, input string tag);
      check_eq({tag, "_busy"}, 32'(busy_v[inst]), 32'd0);
      check_eq({tag, "_done"}, 32'(done_v[inst]), 32'd0);
      check_eq({tag, "_pass"}, 32'(pass_v[inst]), 32'd0);
      check_eq({tag, "_mask"}, 32'(mask_v[inst]), 32'd0);
      check_eq({tag, "_err"},  32'(err_v[inst]),  32'd0);
      check_eq({tag, "_a"},    32'(a_v[inst]),    32'd0);
      check_eq({tag, "_b"},    32'(b_v[inst]),    32'd0);
   endtask

   // Full run from start at cycle T; optional re-pulse of start at T+repulse
   task automatic run_check(input int inst, input int settle, input int passes,
                            input logic [6:0] exp_mask, input logic [7:0] exp_err,
                            input int repulse);
      int         len;
      logic [1:0] idx;
      len = 4 * (settle + 1) * passes;
      start_v[inst] = 1'b1;
      tick();
      start_v[inst] = 1'b0;
      for (int k = 1; k <= len; k++) begin
         if (k > 1) tick();
         start_v[inst] = (k == repulse);
         idx = 2'(((k - 1) / (settle + 1)) % 4);
         check_eq("run_busy",  32'(busy_v[inst]), 32'd1);
         check_eq("run_done",  32'(done_v[inst]), 32'd0);
         check_eq("run_a_drv", 32'(a_v[inst]),    32'(idx[1]));
         check_eq("run_b_drv", 32'(b_v[inst]),    32'(idx[0]));
      end
      start_v[inst] = 1'b0;
      tick();
      check_eq("end_done", 32'(done_v[inst]), 32'd1);
      check_eq("end_busy", 32'(busy_v[inst]), 32'd0);
      check_eq("end_pass", 32'(pass_v[inst]), 32'(exp_mask == 7'd0));
      check_eq("end_mask", 32'(mask_v[inst]), 32'(exp_mask));
      check_eq("end_err",  32'(err_v[inst]),  32'(exp_err));
      check_eq("end_a",    32'(a_v[inst]),    32'd0);
      check_eq("end_b",    32'(b_v[inst]),    32'd0);
      tick();
      check_eq("idle_done", 32'(done_v[inst]), 32'd0);
      check_eq("idle_busy", 32'(busy_v[inst]), 32'd0);
      check_eq("idle_pass", 32'(pass_v[inst]), 32'(exp_mask == 7'd0));
      check_eq("idle_mask", 32'(mask_v[inst]), 32'(exp_mask));
      check_eq("idle_err",  32'(err_v[inst]),  32'(exp_err));
      tick();
      check_eq("idle2_busy", 32'(busy_v[inst]), 32'd0);
   endtask

   initial begin
      rst     = 1'b1;
      start_v = '0;
      keep_m  = 7'h7F;
      inv_m   = 7'h00;
      tick();
      tick();
      for (int i = 0; i < 3; i++) check_idle_zero(i, "reset");
      rst = 1'b0;
      tick();

      // Ideal gate stage, defaults: done at T+13
      run_check(0, 2, 1, 7'b0000000, 8'd0, 0);

      // xor stuck at 0: mismatches on vectors 01 and 10
      keep_m = 7'b1011111;
      run_check(0, 2, 1, 7'b0100000, 8'd2, 0);
      keep_m = 7'h7F;

      // Inverted NOT over three passes
      inv_m = 7'b0000100;
      run_check(1, 2, 3, 7'b0000100, 8'd12, 0);

      // Every output inverted: 280 mismatches clamp to 255, done at T+41
      inv_m = 7'h7F;
      run_check(2, 0, 10, 7'h7F, 8'd255, 0);

      // Start re-pulsed mid-run is ignored
      inv_m = 7'h00;
      run_check(0, 2, 1, 7'b0000000, 8'd0, 5);

      // Reset mid-run aborts with all outputs cleared and no done
      inv_m = 7'h7F;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      for (int k = 2; k <= 6; k++) begin
         tick();
         if (k == 4) begin
            check_eq("abort_pre_mask", 32'(mask_v[0]), 32'h7F);
            check_eq("abort_pre_err",  32'(err_v[0]),  32'd7);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_zero(0, "abort");
      for (int k = 0; k < 15; k++) begin
         tick();
         check_eq("abort_no_done", 32'(done_v[0]), 32'd0);
         check_eq("abort_no_busy", 32'(busy_v[0]), 32'd0);
      end
      inv_m = 7'h00;
      run_check(0, 2, 1, 7'b0000000, 8'd0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
